// File: rtl/dpu_pkg.sv
// Shared DPU types and constants: pixel type, plane size limits and window-generator FSM states.
package dpu_pkg;

    localparam int MAXPOOL_MAX_WIDTH = 416;
    localparam int DIM_BITS          = 9;

    typedef logic signed [7:0] pixel_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/maxpool_line_buf.sv
// One-row pixel store: synchronous write, two combinational reads at (rd_col-1, rd_col).
// Reads see the stored row immediately; no flow control, the writer owns the pace.
module maxpool_line_buf #(
    parameter int MAX_WIDTH = dpu_pkg::MAXPOOL_MAX_WIDTH,
    parameter int DIM_BITS  = dpu_pkg::DIM_BITS
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [DIM_BITS-1:0] wr_col,
    input  logic signed [7:0]   wr_data,
    input  logic [DIM_BITS-1:0] rd_col,
    output logic signed [7:0]   rd_prev,
    output logic signed [7:0]   rd_cur
);
    import dpu_pkg::*;

    pixel_t              mem [MAX_WIDTH];
    logic [DIM_BITS-1:0] prev_col;

    // Storage is deliberately unreset; every entry read is written earlier in the same frame.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_col] <= wr_data;
        end
    end

    assign prev_col = rd_col - DIM_BITS'(1);
    assign rd_prev  = mem[prev_col];
    assign rd_cur   = mem[rd_col];

endmodule

// File: rtl/maxpool_window_gen.sv
// 2x2/stride-2 window gatherer: window registered 1 cycle after its bottom-right pixel; pix_ready high in RUN,
// no output backpressure. Define MAXPOOL_WIN_PERF_EN to add the saturating win_count output.
module maxpool_window_gen #(
    parameter int MAX_WIDTH = dpu_pkg::MAXPOOL_MAX_WIDTH,
    parameter int DIM_BITS  = dpu_pkg::DIM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DIM_BITS-1:0] cfg_width,
    input  logic [DIM_BITS-1:0] cfg_height,
    input  logic                pix_valid,
    input  logic signed [7:0]   pix_data,
    output logic                pix_ready,
    output logic                win_valid,
    output logic signed [7:0]   win_a,
    output logic signed [7:0]   win_b,
    output logic signed [7:0]   win_c,
    output logic signed [7:0]   win_d,
    output logic                busy,
    output logic                frame_done
`ifdef MAXPOOL_WIN_PERF_EN
    ,
    output logic [15:0]         win_count
`endif
);
    import dpu_pkg::*;

    localparam logic [DIM_BITS-1:0] ONE   = DIM_BITS'(1);
    localparam logic [DIM_BITS-1:0] MAX_W = DIM_BITS'(MAX_WIDTH);

    state_t              state, state_nxt;
    logic [DIM_BITS-1:0] width_q, height_q, row, col;
    logic                cfg_ok, accept, xfer, col_last, row_last, frame_end, win_hit;
    pixel_t              hold_c, buf_prev, buf_cur;

    assign cfg_ok    = (cfg_width != '0) && (cfg_width <= MAX_W) && (cfg_height != '0);
    assign xfer      = (state == ST_RUN) && pix_valid;
    assign col_last  = (col == width_q - ONE);
    assign row_last  = (row == height_q - ONE);
    assign frame_end = xfer && col_last && row_last;
    assign win_hit   = xfer && row[0] && col[0];
    assign busy      = (state == ST_RUN);
    assign pix_ready = (state == ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && cfg_ok) begin
                    state_nxt = ST_RUN;
                    accept    = 1'b1;
                end
            end
            ST_RUN: begin
                if (frame_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_q  <= '0;
            height_q <= '0;
            row      <= '0;
            col      <= '0;
        end else if (accept) begin
            width_q  <= cfg_width;
            height_q <= cfg_height;
            row      <= '0;
            col      <= '0;
        end else if (xfer) begin
            if (col_last) begin
                col <= '0;
                row <= row + ONE;
            end else begin
                col <= col + ONE;
            end
        end
    end

    // A rejected start still pulses frame_done so the sequencer never waits on a frame that will not run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end || ((state == ST_IDLE) && start && !cfg_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_a     <= '0;
            win_b     <= '0;
            win_c     <= '0;
            win_d     <= '0;
            hold_c    <= '0;
        end else begin
            win_valid <= win_hit;
            if (xfer && row[0] && !col[0]) begin
                hold_c <= pix_data;
            end
            if (win_hit) begin
                win_a <= buf_prev;
                win_b <= buf_cur;
                win_c <= hold_c;
                win_d <= pix_data;
            end
        end
    end

    maxpool_line_buf #(
        .MAX_WIDTH (MAX_WIDTH),
        .DIM_BITS  (DIM_BITS)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (xfer && !row[0]),
        .wr_col  (col),
        .wr_data (pix_data),
        .rd_col  (col),
        .rd_prev (buf_prev),
        .rd_cur  (buf_cur)
    );

`ifdef MAXPOOL_WIN_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_count <= '0;
        end else if (accept) begin
            win_count <= '0;
        end else if (win_valid && (win_count != 16'hFFFF)) begin
            win_count <= win_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_maxpool_window_gen.sv
// Randomized directed bench for maxpool_window_gen against a tile-level reference model.
module tb_maxpool_window_gen;
    import dpu_pkg::*;

    localparam int MW = MAXPOOL_MAX_WIDTH;
    localparam int DB = DIM_BITS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [DB-1:0]     cfg_width = '0;
    logic [DB-1:0]     cfg_height = '0;
    logic              pix_valid = 1'b0;
    logic signed [7:0] pix_data = '0;
    logic              pix_ready, win_valid, busy, frame_done;
    logic signed [7:0] win_a, win_b, win_c, win_d;
`ifdef MAXPOOL_WIN_PERF_EN
    logic [15:0]       win_count;
`endif

    maxpool_window_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .win_valid  (win_valid),
        .win_a      (win_a),
        .win_b      (win_b),
        .win_c      (win_c),
        .win_d      (win_d),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef MAXPOOL_WIN_PERF_EN
        ,
        .win_count  (win_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int c;
        int d;
        int t;
    } win_t;

    int   cyc = 0;
    win_t got_win[$];
    win_t exp_win[$];
    int   got_fd[$];
    int   exp_fd[$];
    int   pix  [2048];
    int   xcyc [2048];
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin : monitor
        win_t w;
        #1;
        if (win_valid === 1'b1) begin
            w.a = int'(win_a);
            w.b = int'(win_b);
            w.c = int'(win_c);
            w.d = int'(win_d);
            w.t = cyc;
            got_win.push_back(w);
        end
        if (frame_done === 1'b1) got_fd.push_back(cyc);
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic fill_rand(input int base, input int n);
        for (int i = 0; i < n; i++) pix[base + i] = int'($urandom_range(255)) - 128;
    endtask

    task automatic do_start(input int w, input int h);
        @(negedge clk);
        start      = 1'b1;
        cfg_width  = DB'(w);
        cfg_height = DB'(h);
        pix_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start     = 1'b0;
            pix_valid = 1'b0;
        end
    endtask

    // Returns at the negedge where the last pixel was presented; it transfers on the next edge.
    task automatic run_pixels(input int base, input int from, input int to, input int gap);
        int idx;
        int guard;
        idx   = from;
        guard = 0;
        while (idx < to && guard < 20000) begin
            @(negedge clk);
            start     = 1'b0;
            pix_valid = ($urandom_range(99) >= gap);
            pix_data  = 8'(pix[base + idx]);
            if (pix_valid && pix_ready) begin
                xcyc[base + idx] = cyc;
                idx++;
            end
            guard++;
        end
        if (idx < to) chk("drive_timeout", idx, to);
    endtask

    // Reference: each non-overlapping 2x2 tile, due one cycle after its bottom-right pixel transfers.
    task automatic add_exp(input int base, input int w, input int h);
        win_t e;
        for (int r = 0; r < h / 2; r++) begin
            for (int c = 0; c < w / 2; c++) begin
                e.a = pix[base + (2 * r) * w + 2 * c];
                e.b = pix[base + (2 * r) * w + 2 * c + 1];
                e.c = pix[base + (2 * r + 1) * w + 2 * c];
                e.d = pix[base + (2 * r + 1) * w + 2 * c + 1];
                e.t = xcyc[base + (2 * r + 1) * w + 2 * c + 1] + 1;
                exp_win.push_back(e);
            end
        end
        exp_fd.push_back(xcyc[base + w * h - 1] + 1);
    endtask

    task automatic check_all(input string tag);
        int n;
        chk({tag, "_nwin"}, got_win.size(), exp_win.size());
        n = (got_win.size() < exp_win.size()) ? got_win.size() : exp_win.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_a"}, got_win[i].a, exp_win[i].a);
            chk({tag, "_b"}, got_win[i].b, exp_win[i].b);
            chk({tag, "_c"}, got_win[i].c, exp_win[i].c);
            chk({tag, "_d"}, got_win[i].d, exp_win[i].d);
            chk({tag, "_wcyc"}, got_win[i].t, exp_win[i].t);
        end
        chk({tag, "_nfd"}, got_fd.size(), exp_fd.size());
        n = (got_fd.size() < exp_fd.size()) ? got_fd.size() : exp_fd.size();
        for (int i = 0; i < n; i++) chk({tag, "_fdcyc"}, got_fd[i], exp_fd[i]);
        got_win.delete();
        exp_win.delete();
        got_fd.delete();
        exp_fd.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, pix_ready, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_wvld"}, win_valid, 1'b0);
        chk({tag, "_fd"}, frame_done, 1'b0);
        chk({tag, "_wa"}, win_a, 0);
        chk({tag, "_wb"}, win_b, 0);
        chk({tag, "_wc"}, win_c, 0);
        chk({tag, "_wd"}, win_d, 0);
`ifdef MAXPOOL_WIN_PERF_EN
        chk({tag, "_wcnt"}, win_count, 0);
`endif
    endtask

    int bad_w [3];
    int bad_h [3];

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst = 1'b0;
        idle(2);

        // 4x4 ramp, continuous valid
        for (int i = 0; i < 16; i++) pix[i] = i;
        do_start(4, 4);
        run_pixels(0, 0, 16, 0);
        idle(4);
        add_exp(0, 4, 4);
        check_all("f4x4");

        // Signed extremes, 2x2
        pix[0] = -128; pix[1] = 127; pix[2] = -1; pix[3] = 0;
        do_start(2, 2);
        run_pixels(0, 0, 4, 0);
        idle(4);
        if (got_win.size() > 0)
            chk("f2x2_max", max4(got_win[0].a, got_win[0].b, got_win[0].c, got_win[0].d), 127);
        add_exp(0, 2, 2);
        check_all("f2x2");

        // 5x3 with 50% valid gaps: odd column and odd row produce nothing
        fill_rand(0, 15);
        do_start(5, 3);
        run_pixels(0, 0, 15, 50);
        idle(4);
        add_exp(0, 5, 3);
        check_all("f5x3");

        // Rejected configurations
        bad_w[0] = 0;      bad_h[0] = 3;
        bad_w[1] = MW + 1; bad_h[1] = 3;
        bad_w[2] = 4;      bad_h[2] = 0;
        for (int k = 0; k < 3; k++) begin
            do_start(bad_w[k], bad_h[k]);
            @(negedge clk);
            start = 1'b0;
            chk("cfgerr_fd", frame_done, 1'b1);
            chk("cfgerr_busy", busy, 1'b0);
            chk("cfgerr_ready", pix_ready, 1'b0);
            @(negedge clk);
            chk("cfgerr_fd_off", frame_done, 1'b0);
            chk("cfgerr_busy2", busy, 1'b0);
        end
        got_fd.delete();

        // Reset mid-frame, then a clean 4x4 frame
        fill_rand(0, 16);
        do_start(4, 4);
        run_pixels(0, 0, 6, 0);
        @(negedge clk);
        pix_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        got_win.delete();
        got_fd.delete();
        idle(2);
        fill_rand(0, 16);
        do_start(4, 4);
        run_pixels(0, 0, 16, 0);
        idle(4);
        add_exp(0, 4, 4);
        check_all("after_rst");

        // Back-to-back frames with gaps, including a 1x1 frame
        fill_rand(0, 60);
        do_start(6, 4);
        run_pixels(0, 0, 24, 30);
        do_start(7, 5);
        run_pixels(24, 0, 35, 30);
        do_start(1, 1);
        run_pixels(59, 0, 1, 0);
        idle(4);
        add_exp(0, 6, 4);
        add_exp(24, 7, 5);
        add_exp(59, 1, 1);
        check_all("b2b");

`ifdef MAXPOOL_WIN_PERF_EN
        // Full-width frame with a stray start pulse mid-run
        fill_rand(0, 2 * MW);
        do_start(MW, 2);
        run_pixels(0, 0, 100, 0);
        start     = 1'b1;
        cfg_width = DB'(4);
        run_pixels(0, 100, 2 * MW, 0);
        idle(4);
        chk("perf_busy_end", busy, 1'b0);
        add_exp(0, MW, 2);
        check_all("f416x2");
        chk("perf_wcnt", win_count, MW / 2);
        do_start(2, 2);
        idle(1);
        chk("perf_wcnt_clr", win_count, 0);
        run_pixels(0, 0, 4, 0);
        idle(4);
        add_exp(0, 2, 2);
        check_all("perf_2x2");
        chk("perf_wcnt2", win_count, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
